handshake_elastic_fifo: RTL and testbench
=========================================

HANDSHAKE_ELASTIC_FIFO -- requirements
Module: handshake_elastic_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the payload width in bits.
REQ-002 Parameter DEPTH, default 4, SHALL set the storage slots; legal range 2..64; need not be a power of two.
REQ-003 One clock; reset is synchronous and active-high: clk SHALL be the single clock and rst SHALL be the synchronous active-high reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 ins  input  DATA_WIDTH  upstream payload, e.g. a constant-generator output.
REQ-007 ins_valid  input  1  upstream token present.
REQ-008 ins_ready  output  1  block accepts a token this cycle.
REQ-009 outs  output  DATA_WIDTH  head-of-queue payload.
REQ-010 outs_valid  output  1  head token present.
REQ-011 outs_ready  input  1  downstream accepts.

Function
REQ-012 Push SHALL occur on a rising edge with ins_valid && ins_ready; pop SHALL occur with outs_valid && outs_ready.
REQ-013 Tokens SHALL leave in arrival order, with none lost or duplicated.
REQ-014 Occupancy counter cnt, width clog2(DEPTH+1): push only +1, pop only -1, both or neither unchanged.
REQ-015 ins_ready SHALL equal (cnt != DEPTH) && !rst, registered-state only, with no combinational path from outs_ready.
REQ-016 outs_valid SHALL equal (cnt != 0) in default build.
REQ-017 outs SHALL equal mem[rd_ptr]; value is don't-care while outs_valid=0, but SHALL hold stable while outs_valid=1 && outs_ready=0.
REQ-018 Default-build latency: a token pushed in cycle N SHALL be visible at outs in cycle N+1 at the earliest.
REQ-019 wr_ptr/rd_ptr SHALL advance on push/pop and wrap from DEPTH-1 to 0.
REQ-020 Full with simultaneous push attempt: ins_ready=0, no push; a pop in that cycle SHALL free a slot visible next cycle.
REQ-021 Empty with outs_ready=1: no pop, pointers and cnt unchanged.
REQ-022 Simultaneous push and pop with 0<cnt<DEPTH: both pointers advance and cnt is unchanged.

Reset
REQ-023 With rst=1 at an edge, cnt, wr_ptr and rd_ptr SHALL be 0. The cycle after, outs_valid=0 and ins_ready=1. mem contents are not reset.
REQ-024 rst mid-operation SHALL discard all stored tokens; a push offered in the reset cycle SHALL be dropped (ins_ready=0 while rst=1).

Configuration
REQ-025 Macro HANDSHAKE_ELASTIC_FIFO_BYPASS_EN, when defined, SHALL add a zero-latency bypass.
REQ-026 Bypass behaviour: when cnt=0, outs=ins and outs_valid=ins_valid. If outs_ready=1, the token passes the same cycle without being written; otherwise it is stored normally.
REQ-027 With the macro undefined, REQ-016/REQ-018 apply and no combinational ins->outs path SHALL exist.

Structure
REQ-028 Shared package handshake_pkg SHALL hold the ptr/count width helper function and the DEPTH legality constants (min 2, max 64).
REQ-029 Storage SHALL be a sub-module, handshake_elastic_fifo_mem: DEPTH x DATA_WIDTH, 1 write port, 1 asynchronous read port.
REQ-030 Pointer and count control SHALL remain in the top module.

Verification
REQ-031 DATA_WIDTH=14, DEPTH=4, outs_ready=1; push 0x3B2B for one cycle -> outs=0x3B2B with outs_valid=1 on the next cycle only (default build).
REQ-032 outs_ready=0; push 0x0001..0x0004 -> ins_ready=0 after the 4th push. Then outs_ready=1 -> pops 0x0001,0x0002,0x0003,0x0004 in order, with ins_ready=1 the cycle after the first pop.
REQ-033 cnt=4 (full), ins_valid=1, outs_ready=1 same cycle -> 1 pop, 0 pushes, cnt=3; next cycle push accepted, cnt stays 3.
REQ-034 Random valid/ready at 50% each for 10,000 cycles, DEPTH=3 -> scoreboard order match and wrap exercised; zero lost or duplicated tokens.
REQ-035 Load 2 tokens then assert rst 1 cycle -> outs_valid=0 next cycle, and a post-reset push of 0x00AA emerges as the first output.
REQ-036 BYPASS_EN defined, empty, ins_valid=1, ins=0x1234, outs_ready=1 -> outs=0x1234, outs_valid=1 the same cycle, cnt stays 0.

Source files
------------

// File: rtl/handshake_pkg.sv
// Shared constants and width helpers for the elastic handshake FIFO.
// Holds the DEPTH legality bounds and pointer/count width functions.
package handshake_pkg;

  localparam int HS_DEPTH_MIN = 2;
  localparam int HS_DEPTH_MAX = 64;

  // Pointer width; never below 1 so tiny depths still get a real bus.
  function automatic int hs_ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int hs_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit hs_depth_ok(input int depth);
    return (depth >= HS_DEPTH_MIN) && (depth <= HS_DEPTH_MAX);
  endfunction

endpackage

// File: rtl/handshake_elastic_fifo_mem.sv
// Storage array for the elastic FIFO: DEPTH x DATA_WIDTH, 1 write port,
// 1 asynchronous read port. Contents are never reset.
// Ports: i_clk, i_we/i_waddr/i_wdata (write), i_raddr/o_rdata (read).
module handshake_elastic_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int AW         = 2
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/handshake_elastic_fifo.sv
// Elastic valid/ready FIFO with in-order delivery and a sync reset.
// Ports: clk, rst (sync, active-high); ins/ins_valid/ins_ready upstream;
// outs/outs_valid/outs_ready downstream. Params DATA_WIDTH, DEPTH (2..64).
// Define HANDSHAKE_ELASTIC_FIFO_BYPASS_EN for a zero-latency empty bypass.
module handshake_elastic_fifo
  import handshake_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int PW = hs_ptr_width(DEPTH);
  localparam int CW = hs_cnt_width(DEPTH);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  generate
    if (!hs_depth_ok(DEPTH)) begin : g_bad_depth
      $error("handshake_elastic_fifo: DEPTH out of range");
    end
  endgenerate

  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_cnt;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_byp;
  logic [DATA_WIDTH-1:0] w_rdata;

  function automatic logic [PW-1:0] f_inc(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == FULL);

  // Depends only on registered count and rst, never on outs_ready.
  assign ins_ready = !w_full && !rst;

`ifdef HANDSHAKE_ELASTIC_FIFO_BYPASS_EN
  // Empty FIFO forwards the upstream token directly; it is only
  // written when downstream stalls. rst gates it so a token refused
  // upstream is never shown downstream.
  assign w_byp      = w_empty && ins_valid && outs_ready && !rst;
  assign outs_valid = !w_empty || (ins_valid && !rst);
  assign outs       = w_empty ? ins : w_rdata;
`else
  assign w_byp      = 1'b0;
  assign outs_valid = !w_empty;
  assign outs       = w_rdata;
`endif

  assign w_push = ins_valid && ins_ready && !w_byp;
  assign w_pop  = !w_empty && outs_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= f_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_inc(r_rd_ptr);
      end
      unique case (1'b1)
        (w_push && !w_pop): r_cnt <= r_cnt + CW'(1);
        (w_pop && !w_push): r_cnt <= r_cnt - CW'(1);
        default:            r_cnt <= r_cnt;
      endcase
    end
  end

  handshake_elastic_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (PW)
  ) u_mem (
    .i_clk  (clk),
    .i_we   (w_push),
    .i_waddr(r_wr_ptr),
    .i_wdata(ins),
    .i_raddr(r_rd_ptr),
    .o_rdata(w_rdata)
  );

endmodule

// File: tb/tb_handshake_elastic_fifo.sv
// Scoreboard bench for handshake_elastic_fifo: lane 0 DEPTH=4,
// lane 1 DEPTH=3, both DATA_WIDTH=14, checked against a queue model.
module tb_handshake_elastic_fifo;

  localparam int DW = 14;

  logic          clk = 1'b0;
  logic          rst        [2];
  logic [DW-1:0] ins        [2];
  logic          ins_valid  [2];
  logic          ins_ready  [2];
  logic [DW-1:0] outs       [2];
  logic          outs_valid [2];
  logic          outs_ready [2];

  logic [DW-1:0] exp_q [2][$];

  int errors = 0;
  int checks = 0;
  bit m_ready [2];
  bit m_byp   [2];
  bit done_req = 1'b0;
  bit done_ack = 1'b0;

  always #5 clk = ~clk;

  handshake_elastic_fifo #(.DATA_WIDTH(DW), .DEPTH(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst[0]),
    .ins       (ins[0]),
    .ins_valid (ins_valid[0]),
    .ins_ready (ins_ready[0]),
    .outs      (outs[0]),
    .outs_valid(outs_valid[0]),
    .outs_ready(outs_ready[0])
  );

  handshake_elastic_fifo #(.DATA_WIDTH(DW), .DEPTH(3)) u_dut3 (
    .clk       (clk),
    .rst       (rst[1]),
    .ins       (ins[1]),
    .ins_valid (ins_valid[1]),
    .ins_ready (ins_ready[1]),
    .outs      (outs[1]),
    .outs_valid(outs_valid[1]),
    .outs_ready(outs_ready[1])
  );

  function automatic int dep_of(input int l);
    return (l == 0) ? 4 : 3;
  endfunction

  task automatic check(input string name, input int l,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d: got %h expected %h",
               name, l, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs with the model and retires tokens.
  initial begin
    forever begin
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        int            n;
        bit            er;
        bit            ev;
        logic [DW-1:0] eo;
        n  = exp_q[l].size();
        er = (n != dep_of(l)) && !rst[l];
        ev = (n != 0);
        eo = (n != 0) ? exp_q[l][0] : '0;
`ifdef HANDSHAKE_ELASTIC_FIFO_BYPASS_EN
        if (n == 0) begin
          ev = ins_valid[l] && !rst[l];
          eo = ins[l];
        end
`endif
        check("ins_ready", l, 32'(ins_ready[l]), 32'(er));
        check("outs_valid", l, 32'(outs_valid[l]), 32'(ev));
        if (ev) begin
          check("outs", l, 32'(outs[l]), 32'(eo));
        end
        m_ready[l] = er;
        m_byp[l]   = 1'b0;
        if (ev && outs_ready[l]) begin
          if (n != 0) void'(exp_q[l].pop_front());
          else m_byp[l] = 1'b1;
        end
        if (rst[l]) exp_q[l].delete();
      end
      if (done_req && !done_ack) begin
        for (int l = 0; l < 2; l++) begin
          check("leftover", l, 32'(exp_q[l].size()), 32'd0);
        end
        done_ack = 1'b1;
      end
    end
  end

  // One clock: model records accepted pushes after the monitor ran.
  task automatic tick();
    @(negedge clk);
    #1;
    for (int l = 0; l < 2; l++) begin
      if (ins_valid[l] && m_ready[l] && !m_byp[l]) begin
        exp_q[l].push_back(ins[l]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int l, input bit v,
                       input logic [DW-1:0] d, input bit r);
    ins_valid[l]  = v;
    ins[l]        = d;
    outs_ready[l] = r;
  endtask

  initial begin
    for (int l = 0; l < 2; l++) begin
      rst[l] = 1'b1;
      drive(l, 1'b0, '0, 1'b1);
    end
    tick();
    tick();
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // single token latency
    drive(0, 1'b1, 14'h3B2B, 1'b1);
    tick();
    drive(0, 1'b0, '0, 1'b1);
    tick();
    tick();

    // fill to full, refused push, ordered drain
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1'b1, 14'(i), 1'b0);
      tick();
    end
    drive(0, 1'b1, 14'h0005, 1'b0);
    tick();
    drive(0, 1'b0, '0, 1'b1);
    repeat (6) tick();

    // full with push attempt and pop together
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1'b1, 14'(16 + i), 1'b0);
      tick();
    end
    drive(0, 1'b1, 14'h0100, 1'b1);
    tick();
    drive(0, 1'b1, 14'h0101, 1'b1);
    tick();
    drive(0, 1'b0, '0, 1'b1);
    repeat (6) tick();

    // reset mid-operation, push in reset cycle dropped
    drive(0, 1'b1, 14'h0011, 1'b0);
    tick();
    drive(0, 1'b1, 14'h0022, 1'b0);
    tick();
    rst[0] = 1'b1;
    drive(0, 1'b1, 14'h0077, 1'b0);
    tick();
    rst[0] = 1'b0;
    drive(0, 1'b1, 14'h00AA, 1'b0);
    tick();
    drive(0, 1'b0, '0, 1'b0);
    tick();
    drive(0, 1'b0, '0, 1'b1);
    repeat (3) tick();

    // random traffic on both lanes
    repeat (10000) begin
      for (int l = 0; l < 2; l++) begin
        drive(l, 1'($urandom_range(0, 1)), DW'($urandom),
              1'($urandom_range(0, 1)));
      end
      tick();
    end

    for (int l = 0; l < 2; l++) drive(l, 1'b0, '0, 1'b1);
    repeat (8) tick();
    done_req = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
